// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the bit-serial adder/subtractor.
//   ST_IDLE / ST_RUN : FSM state encoding
//   DEFAULT_WIDTH    : default operand width
//   clog2()          : width of the bit counter for a given operand width
package serial_adder_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: single-bit full adder, purely combinational.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out (majority of a, b, cin)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half;

  // Two half adders plus an OR, as in the single-bit adder tile.
  assign half = a ^ b;
  assign s    = half ^ cin;
  assign cout = (a & b) | (cin & half);

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor, LSB first, one bit per clock.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, sampled only while idle
//   sub   : 0 = a+b, 1 = a-b (sampled with start)
//   a, b  : operands (sampled with start)
//   busy  : high while bits are processed
//   done  : one-cycle pulse when the result becomes valid
//   sum   : result, held from done until the next accepted start
//   cout  : final carry; for subtraction 1 means no borrow
//   ovf   : signed two's-complement overflow of the result
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             state;
  logic             state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             last_bit;

  assign accept   = (state == ST_IDLE) && start;
  assign last_bit = (state == ST_RUN) && (cnt == LAST);

  fa_cell u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)    state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == ST_RUN);
  end

  // Control and result registers: carry, counter, done, sum, cout, ovf
  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= last_bit;
      if (accept) begin
        // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
        carry <= sub;
        cnt   <= '0;
        sum   <= '0;
        cout  <= 1'b0;
        ovf   <= 1'b0;
      end else if (state == ST_RUN) begin
        sum   <= {fa_s, sum[WIDTH-1:1]};
        carry <= fa_c;
        cnt   <= cnt + CNT_W'(1);
        if (last_bit) begin
          cout <= fa_c;
          // Carry into the sign bit differing from carry out means overflow.
          ovf  <= carry ^ fa_c;
        end
      end
    end
  end

  // Operand shift registers; contents are don't-care outside RUN
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= sub ? ~b : b;
    end else if (state == ST_RUN) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed bench for serial_adder at WIDTH 8, 16 and 2.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  logic        start2 = 1'b0, sub2 = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic        busy2, done2, cout2, ovf2;
  logic [1:0]  sum2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accepting edge until done8 rises (bounded),
  // and how many of the samples before that showed busy8 high.
  task automatic wait_done8(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    while (!done8 && edges < 40) begin
      if (busy8) busy_cnt++;
      step();
      edges++;
    end
  endtask

  // Start one 8-bit operation from idle, return done latency in edges.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                      output int edges, output int busy_cnt);
    start8 = 1'b1; a8 = av; b8 = bv; sub8 = sv;
    step();
    start8 = 1'b0;
    wait_done8(edges, busy_cnt);
  endtask

  initial begin
    int edges, busy_cnt, pulses;

    // Reset state
    step(); step();
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum",  32'(sum8),  32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    check("rst_ovf",  32'(ovf8),  32'd0);
    rst = 1'b0;
    step();

    // 3 + 5: latency and busy length
    run8(8'd3, 8'd5, 1'b0, edges, busy_cnt);
    check("add35_latency_edges", 32'(edges), 32'd8);
    check("add35_busy_cycles", 32'(busy_cnt), 32'd8);
    check("add35_busy_at_done", 32'(busy8), 32'd0);
    check("add35_sum",  32'(sum8),  32'd8);
    check("add35_cout", 32'(cout8), 32'd0);
    check("add35_ovf",  32'(ovf8),  32'd0);
    step();
    check("add35_done_one_cycle", 32'(done8), 32'd0);
    check("add35_sum_held", 32'(sum8), 32'd8);

    // 255 + 1
    run8(8'd255, 8'd1, 1'b0, edges, busy_cnt);
    check("add255_done", 32'(done8), 32'd1);
    check("add255_sum",  32'(sum8),  32'd0);
    check("add255_cout", 32'(cout8), 32'd1);
    check("add255_ovf",  32'(ovf8),  32'd0);

    // 127 + 1: signed overflow
    run8(8'd127, 8'd1, 1'b0, edges, busy_cnt);
    check("add127_sum",  32'(sum8),  32'd128);
    check("add127_cout", 32'(cout8), 32'd0);
    check("add127_ovf",  32'(ovf8),  32'd1);

    // Subtraction
    run8(8'd5, 8'd3, 1'b1, edges, busy_cnt);
    check("sub53_sum",  32'(sum8),  32'd2);
    check("sub53_cout", 32'(cout8), 32'd1);
    check("sub53_ovf",  32'(ovf8),  32'd0);
    run8(8'd3, 8'd5, 1'b1, edges, busy_cnt);
    check("sub35_sum",  32'(sum8),  32'd254);
    check("sub35_cout", 32'(cout8), 32'd0);
    check("sub35_ovf",  32'(ovf8),  32'd0);
    run8(8'd128, 8'd1, 1'b1, edges, busy_cnt);
    check("sub128_sum",  32'(sum8),  32'd127);
    check("sub128_cout", 32'(cout8), 32'd1);
    check("sub128_ovf",  32'(ovf8),  32'd1);
    step();

    // Start while busy is ignored
    start8 = 1'b1; a8 = 8'd10; b8 = 8'd20; sub8 = 1'b0;
    step();
    start8 = 1'b0;
    step(); step();
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd1; sub8 = 1'b1;
    step();
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; sub8 = 1'b0;
    wait_done8(edges, busy_cnt);
    check("busy_start_latency_edges", 32'(edges + 3), 32'd8);
    check("busy_start_sum", 32'(sum8), 32'd30);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8) pulses++;
    end
    check("busy_start_extra_done", 32'(pulses), 32'd0);
    check("busy_start_idle", 32'(busy8), 32'd0);

    // Start held high: back-to-back, second start accepted in the done cycle
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd5; sub8 = 1'b0;
    step();
    wait_done8(edges, busy_cnt);
    check("b2b_first_sum", 32'(sum8), 32'd8);
    a8 = 8'd1; b8 = 8'd2;
    step();
    check("b2b_second_accepted", 32'(busy8), 32'd1);
    check("b2b_sum_cleared", 32'(sum8), 32'd0);
    check("b2b_done_dropped", 32'(done8), 32'd0);
    wait_done8(edges, busy_cnt);
    start8 = 1'b0;
    check("b2b_done_spacing", 32'(edges + 1), 32'd9);
    check("b2b_second_sum", 32'(sum8), 32'd3);
    wait_done8(edges, busy_cnt);
    step();
    step();

    // Reset mid-run aborts without a done pulse
    start8 = 1'b1; a8 = 8'd50; b8 = 8'd60; sub8 = 1'b0;
    step();
    start8 = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_sum",  32'(sum8),  32'd0);
    check("abort_done", 32'(done8), 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) pulses++;
      step();
    end
    check("abort_no_activity", 32'(pulses), 32'd0);
    run8(8'd6, 8'd7, 1'b0, edges, busy_cnt);
    check("after_abort_latency_edges", 32'(edges), 32'd8);
    check("after_abort_sum", 32'(sum8), 32'd13);
    check("after_abort_cout", 32'(cout8), 32'd0);

    // WIDTH=16: 6 + 7
    start16 = 1'b1; a16 = 16'd6; b16 = 16'd7; sub16 = 1'b0;
    step();
    start16 = 1'b0;
    edges = 0;
    while (!done16 && edges < 40) begin
      step();
      edges++;
    end
    check("w16_latency_edges", 32'(edges), 32'd16);
    check("w16_sum",  32'(sum16),  32'd13);
    check("w16_cout", 32'(cout16), 32'd0);
    check("w16_ovf",  32'(ovf16),  32'd0);

    // WIDTH=2: 6 + 7 truncated to 2 + 3 -> 1 carry 1, signed -2 + -1 overflows
    start2 = 1'b1; a2 = 2'b10; b2 = 2'b11; sub2 = 1'b0;
    step();
    start2 = 1'b0;
    edges = 0;
    while (!done2 && edges < 40) begin
      step();
      edges++;
    end
    check("w2_latency_edges", 32'(edges), 32'd2);
    check("w2_sum",  32'(sum2),  32'd1);
    check("w2_cout", 32'(cout2), 32'd1);
    check("w2_ovf",  32'(ovf2),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
